// File: rtl/vending_pkg.sv
// Shared coin and controller-state encodings for the multi-item vending controller.
package vending_pkg;

    localparam int unsigned COIN_W = 2;

    typedef enum logic [COIN_W-1:0] {
        NONE    = 2'd0,
        NICKEL  = 2'd1,
        DIME    = 2'd2,
        QUARTER = 2'd3
    } coin_t;

    typedef enum logic [1:0] {
        ACCEPT   = 2'd0,
        CHANGE   = 2'd1,
        DISPENSE = 2'd2,
        REFUND   = 2'd3
    } state_t;

    // Coin worth in nickel units.
    function automatic logic [2:0] coin_value(input coin_t c);
        case (c)
            NICKEL:  coin_value = 3'd1;
            DIME:    coin_value = 3'd2;
            QUARTER: coin_value = 3'd5;
            default: coin_value = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_change_calc.sv
// Change-making helper: can rem nickels be paid from the dime/nickel tubes, and which coin goes next.
module vend_change_calc
    import vending_pkg::*;
#(
    parameter int unsigned CNT_W = 4,
    parameter int unsigned CR_W  = 4
) (
    input  logic [CR_W-1:0]  rem,
    input  logic [CNT_W-1:0] t5,
    input  logic [CNT_W-1:0] t10,
    output logic             feasible,
    output logic [1:0]       coin
);

    localparam int unsigned W = ((CNT_W > CR_W) ? CNT_W : CR_W) + 1;

    logic [W-1:0] half;
    logic [W-1:0] dimes;
    logic [W-1:0] need;

    // Greedy: as many dimes as possible, nickels cover whatever is left.
    always_comb begin
        half     = W'(rem >> 1);
        dimes    = (W'(t10) < half) ? W'(t10) : half;
        need     = W'(rem) - (dimes << 1);
        feasible = (W'(t5) >= need);
        coin     = ((rem >= CR_W'(2)) && (t10 != '0)) ? DIME : NICKEL;
    end

endmodule

// File: rtl/vending_multi_ctrl.sv
// Multi-item vending controller: coin intake into tubes, selection, change making, refund and stock tracking.
module vending_multi_ctrl
    import vending_pkg::*;
#(
    parameter int unsigned CNT_W      = 4,
    parameter int unsigned CR_W       = 4,
    parameter int unsigned PRICE      = 5,
    parameter int unsigned MAX_CREDIT = 9,
    parameter int unsigned N_ITEMS    = 4,
    parameter int unsigned STOCK_W    = 3,
    parameter int unsigned INIT_STOCK = 7
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [1:0]                 coin_in,
    input  logic                       sel_valid,
    input  logic [$clog2(N_ITEMS)-1:0] sel_item,
    input  logic                       cancel,
    output logic                       coin_accept,
    output logic [1:0]                 change_out,
    output logic                       vend_valid,
    output logic [$clog2(N_ITEMS)-1:0] vend_item,
    output logic [N_ITEMS-1:0]         sold_out,
    output logic [CR_W-1:0]            credit,
    output logic                       busy
);

    localparam int unsigned SEL_W = $clog2(N_ITEMS);
    localparam int unsigned SUM_W = CR_W + 3;

    state_t                          state, state_n;
    logic [CNT_W-1:0]                t5, t10, t25, t5_n, t10_n, t25_n;
    logic [CR_W-1:0]                 l5, l10, l25, l5_n, l10_n, l25_n;
    logic [CR_W-1:0]                 rem, rem_n;
    logic [SEL_W-1:0]                item, item_n;
    logic [N_ITEMS-1:0][STOCK_W-1:0] stock, stock_n;
    coin_t                           change_n;
    logic                            vend_valid_n;
    logic [SEL_W-1:0]                vend_item_n;

    logic [SUM_W-1:0] credit_sum;
    logic [CR_W-1:0]  coin_v;
    logic [CR_W-1:0]  sel_rem;
    logic [CR_W-1:0]  calc_rem;
    logic             calc_feasible;
    logic [1:0]       calc_coin;
    logic             tube_full;
    logic             coin_ok;
    logic             sel_ok;

    assign credit_sum  = SUM_W'(l5) + (SUM_W'(l10) << 1) + (SUM_W'(l25) * SUM_W'(5));
    assign credit      = CR_W'(credit_sum);
    assign busy        = (state != ACCEPT);
    assign coin_accept = (state == ACCEPT) && (credit < CR_W'(MAX_CREDIT));

    always_comb begin
        for (int i = 0; i < int'(N_ITEMS); i++) begin
            sold_out[i] = (stock[i] == '0);
        end
    end

    // The calculator serves the selection check in ACCEPT and the eject choice in CHANGE.
    assign sel_rem  = credit - CR_W'(PRICE);
    assign calc_rem = (state == CHANGE) ? rem : sel_rem;

    vend_change_calc #(
        .CNT_W (CNT_W),
        .CR_W  (CR_W)
    ) u_change_calc (
        .rem      (calc_rem),
        .t5       (t5),
        .t10      (t10),
        .feasible (calc_feasible),
        .coin     (calc_coin)
    );

    always_comb begin
        coin_v = CR_W'(coin_value(coin_t'(coin_in)));
        case (coin_t'(coin_in))
            NICKEL:  tube_full = (t5 == {CNT_W{1'b1}});
            DIME:    tube_full = (t10 == {CNT_W{1'b1}});
            QUARTER: tube_full = (t25 == {CNT_W{1'b1}});
            default: tube_full = 1'b0;
        endcase
        coin_ok = (coin_t'(coin_in) != NONE) && coin_accept && !tube_full
                  && (({1'b0, credit} + {1'b0, coin_v}) <= (CR_W+1)'(MAX_CREDIT));
        sel_ok  = sel_valid && (credit >= CR_W'(PRICE))
                  && ({1'b0, sel_item} < (SEL_W+1)'(N_ITEMS))
                  && (stock[sel_item] != '0);
    end

    // Next-state and next-output logic; an unused incoming coin is returned by default.
    always_comb begin
        state_n      = state;
        t5_n         = t5;
        t10_n        = t10;
        t25_n        = t25;
        l5_n         = l5;
        l10_n        = l10;
        l25_n        = l25;
        rem_n        = rem;
        item_n       = item;
        stock_n      = stock;
        change_n     = coin_t'(coin_in);
        vend_valid_n = 1'b0;
        vend_item_n  = vend_item;

        case (state)
            ACCEPT: begin
                if (cancel && (credit != '0)) begin
                    state_n = REFUND;
                end else if (sel_ok) begin
                    item_n  = sel_item;
                    rem_n   = sel_rem;
                    state_n = calc_feasible ? CHANGE : REFUND;
                end else if (coin_ok) begin
                    change_n = NONE;
                    case (coin_t'(coin_in))
                        NICKEL: begin
                            t5_n = t5 + CNT_W'(1);
                            l5_n = l5 + CR_W'(1);
                        end
                        DIME: begin
                            t10_n = t10 + CNT_W'(1);
                            l10_n = l10 + CR_W'(1);
                        end
                        default: begin
                            t25_n = t25 + CNT_W'(1);
                            l25_n = l25 + CR_W'(1);
                        end
                    endcase
                end
            end

            CHANGE: begin
                if (rem == '0) begin
                    state_n = DISPENSE;
                end else if (calc_coin == DIME) begin
                    change_n = DIME;
                    t10_n    = t10 - CNT_W'(1);
                    rem_n    = rem - CR_W'(2);
                    if (l10 != '0) l10_n = l10 - CR_W'(1);
                end else begin
                    change_n = NICKEL;
                    t5_n     = t5 - CNT_W'(1);
                    rem_n    = rem - CR_W'(1);
                    if (l5 != '0) l5_n = l5 - CR_W'(1);
                end
            end

            DISPENSE: begin
                vend_valid_n  = 1'b1;
                vend_item_n   = item;
                stock_n[item] = stock[item] - STOCK_W'(1);
                l5_n          = '0;
                l10_n         = '0;
                l25_n         = '0;
                state_n       = ACCEPT;
            end

            REFUND: begin
                if (l25 != '0) begin
                    change_n = QUARTER;
                    l25_n    = l25 - CR_W'(1);
                    t25_n    = t25 - CNT_W'(1);
                end else if (l10 != '0) begin
                    change_n = DIME;
                    l10_n    = l10 - CR_W'(1);
                    t10_n    = t10 - CNT_W'(1);
                end else if (l5 != '0) begin
                    change_n = NICKEL;
                    l5_n     = l5 - CR_W'(1);
                    t5_n     = t5 - CNT_W'(1);
                end else begin
                    state_n = ACCEPT;
                end
            end

            default: state_n = ACCEPT;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ACCEPT;
            t5         <= '0;
            t10        <= '0;
            t25        <= '0;
            l5         <= '0;
            l10        <= '0;
            l25        <= '0;
            rem        <= '0;
            item       <= '0;
            stock      <= {N_ITEMS{STOCK_W'(INIT_STOCK)}};
            change_out <= NONE;
            vend_valid <= 1'b0;
            vend_item  <= '0;
        end else begin
            state      <= state_n;
            t5         <= t5_n;
            t10        <= t10_n;
            t25        <= t25_n;
            l5         <= l5_n;
            l10        <= l10_n;
            l25        <= l25_n;
            rem        <= rem_n;
            item       <= item_n;
            stock      <= stock_n;
            change_out <= change_n;
            vend_valid <= vend_valid_n;
            vend_item  <= vend_item_n;
        end
    end

endmodule
